// File: rtl/nibble_descrambler_pkg.sv
// Shared types and constants for the x^7+x^4+1 self-synchronising nibble descrambler.
// History bit 0 holds the oldest scrambled bit, bit HIST_W-1 the most recent.
package nibble_descrambler_pkg;

  localparam int HIST_W = 7;
  localparam int NIB_W  = 4;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 7;

  typedef logic [NIB_W-1:0]  nibble_t;
  typedef logic [HIST_W-1:0] hist_t;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_WARM     = 2'd1,
    LOCK_LOCKED   = 2'd2
  } lock_state_e;

  // Lock progression on each accepted nibble. Two nibbles give 8 line bits,
  // which is enough to fill the 7-bit history.
  function automatic lock_state_e lock_advance(lock_state_e cur);
    case (cur)
      LOCK_UNLOCKED: return LOCK_WARM;
      default:       return LOCK_LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/nibble_descrambler_if.sv
// Nibble stream bus: scrambled input (s_*) and descrambled output (m_*) handshakes.
// The descrambler is the slave; the traffic source/sink is the master.
interface nibble_descrambler_if;
  import nibble_descrambler_pkg::*;

  nibble_t s_data;
  logic    s_valid;
  logic    s_ready;
  nibble_t m_data;
  logic    m_valid;
  logic    m_ready;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

endinterface

// File: rtl/nibble_descrambler_descramble_nibble.sv
// Combinational descrambler for one nibble: d_k = s_k ^ s_(k-4) ^ s_(k-7), bit0 first,
// with each bit seeing the bits of the same nibble that precede it on the line.
module descramble_nibble
  import nibble_descrambler_pkg::*;
(
  input  hist_t   hist_in,
  input  nibble_t nib_in,
  output nibble_t data_out,
  output hist_t   hist_out
);

  // Time-ordered line: history (oldest at bit 0) followed by the new nibble,
  // so each tap becomes a plain 4-bit slice and the chaining comes for free.
  logic [HIST_W+NIB_W-1:0] line;

  assign line     = {nib_in, hist_in};
  assign data_out = line[HIST_W +: NIB_W]
                  ^ line[HIST_W-TAP_A +: NIB_W]
                  ^ line[HIST_W-TAP_B +: NIB_W];
  assign hist_out = line[NIB_W +: HIST_W];

endmodule

// File: rtl/nibble_descrambler.sv
// Nibble-wide self-synchronising descrambler with lock tracking, a one-entry
// output register with ready/valid handshakes, and an emitted-nibble counter.
module nibble_descrambler
  import nibble_descrambler_pkg::*;
#(
  parameter bit DROP_UNLOCKED = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  nibble_descrambler_if.slave  bus,
  output logic                 locked,
  output logic [CNT_W-1:0]     nib_cnt
);

  lock_state_e      state_q, state_d;
  logic             locked_q, locked_d;
  hist_t            hist_q, hist_d;
  nibble_t          m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;

  nibble_t desc_data;
  hist_t   desc_hist;
  logic    s_ready;
  logic    s_fire;
  logic    m_fire;
  logic    emit;

  descramble_nibble u_descramble (
    .hist_in  (hist_q),
    .nib_in   (bus.s_data),
    .data_out (desc_data),
    .hist_out (desc_hist)
  );

  // Flush blocks intake so a nibble presented alongside it is never half-absorbed.
  assign s_ready = !flush && (!m_valid_q || bus.m_ready);
  assign s_fire  = bus.s_valid && s_ready;
  assign m_fire  = m_valid_q && bus.m_ready;
  assign emit    = !DROP_UNLOCKED || (state_q != LOCK_UNLOCKED);

  always_comb begin
    // NOTE: every next-state variable gets a default here, so no path can infer a latch.
    state_d   = state_q;
    hist_d    = hist_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    nib_cnt_d = nib_cnt_q + CNT_W'(m_fire);

    if (flush) begin
      state_d   = LOCK_UNLOCKED;
      hist_d    = '0;
      m_data_d  = '0;
      m_valid_d = 1'b0;
    end else begin
      if (m_fire) begin
        m_valid_d = 1'b0;
      end
      // A new nibble landing in the same cycle as a drain refills the register.
      if (s_fire) begin
        hist_d  = desc_hist;
        state_d = lock_advance(state_q);
        if (emit) begin
          m_valid_d = 1'b1;
          m_data_d  = desc_data;
        end
      end
    end

    locked_d = (state_d == LOCK_LOCKED);
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOCK_UNLOCKED;
      locked_q  <= 1'b0;
      hist_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      nib_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      locked_q  <= locked_d;
      hist_q    <= hist_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign locked      = locked_q;
  assign nib_cnt     = nib_cnt_q;

endmodule

// File: tb/tb_nibble_descrambler.sv
// Self-checking bench: three descrambler instances (keep/drop unlocked, narrow counter)
// share one stimulus; outputs are checked against a bit-serial reference model.
module tb_nibble_descrambler;

  typedef int int_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic [3:0] s_data = 4'h0;

  int checks = 0;
  int failures = 0;

  int acc_q[3][$];
  int out_q[3][$];

  logic        locked0, locked1, locked2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  nibble_descrambler_if if0 ();
  nibble_descrambler_if if1 ();
  nibble_descrambler_if if2 ();

  assign if0.s_data = s_data;  assign if0.s_valid = s_valid;  assign if0.m_ready = m_ready;
  assign if1.s_data = s_data;  assign if1.s_valid = s_valid;  assign if1.m_ready = m_ready;
  assign if2.s_data = s_data;  assign if2.s_valid = s_valid;  assign if2.m_ready = m_ready;

  nibble_descrambler #(.DROP_UNLOCKED(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0), .locked(locked0), .nib_cnt(cnt0));
  nibble_descrambler #(.DROP_UNLOCKED(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1), .locked(locked1), .nib_cnt(cnt1));
  nibble_descrambler #(.DROP_UNLOCKED(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if2), .locked(locked2), .nib_cnt(cnt2));

  always #5 clk = ~clk;

  // Record accepted inputs (-1 marks a flush) and emitted outputs, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 3; u++) begin
        acc_q[u].delete();
        out_q[u].delete();
      end
    end else begin
      if (flush) for (int u = 0; u < 3; u++) acc_q[u].push_back(-1);
      if (s_valid && if0.s_ready) acc_q[0].push_back(int'(s_data));
      if (s_valid && if1.s_ready) acc_q[1].push_back(int'(s_data));
      if (s_valid && if2.s_ready) acc_q[2].push_back(int'(s_data));
      if (if0.m_valid && m_ready) out_q[0].push_back(int'(if0.m_data));
      if (if1.m_valid && m_ready) out_q[1].push_back(int'(if1.m_data));
      if (if2.m_valid && m_ready) out_q[2].push_back(int'(if2.m_data));
    end
  end

  // Serial-line reference: d = s ^ s(k-4) ^ s(k-7) with missing history treated as 0.
  function automatic int_q_t model(int_q_t acc, bit drop);
    int_q_t res;
    bit     line[$];
    int     nin = 0;
    foreach (acc[j]) begin
      if (acc[j] < 0) begin
        line.delete();
        nin = 0;
      end else begin
        int d = 0;
        for (int b = 0; b < 4; b++) begin
          int k = line.size();
          bit s = bit'((acc[j] >> b) & 1);
          bit t = s;
          if (k >= 4) t = t ^ line[k-4];
          if (k >= 7) t = t ^ line[k-7];
          d = d | (int'(t) << b);
          line.push_back(s);
        end
        nin++;
        if (!drop || nin >= 2) res.push_back(d);
      end
    end
    return res;
  endfunction

  task automatic drive(input bit v, input logic [3:0] d, input bit mr, input bit fl, output bit acc);
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    acc = v && if0.s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input bit rand_mr);
    bit a;
    int tries = 0;
    do begin
      drive(1'b1, d, rand_mr ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, a);
      tries++;
    end while (!a && tries < 64);
    checks++;
    if (!a) begin
      failures++;
      $display("FAIL send_accept: nibble %0h not accepted within %0d cycles", d, tries);
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b1, 1'b0, a);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (if0.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b want 0", if0.m_valid); end
    checks++; if (if0.m_data !== 4'h0) begin failures++; $display("FAIL reset_m_data: got %h want 0", if0.m_data); end
    checks++; if (locked0 !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b want 0", locked0); end
    checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL reset_nib_cnt: got %0d want 0", cnt0); end
    rst_n = 1'b1;
    #1;
    checks++; if (if0.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready0: got %b want 1", if0.s_ready); end
    checks++; if (if1.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready1: got %b want 1", if1.s_ready); end
  endtask

  task automatic test_known_vectors();
    int exp0[2];
    int got;
    exp0[0] = 15;
    exp0[1] = 7;
    do_reset();
    send(4'hF, 1'b0);
    checks++; if (locked0 !== 1'b0) begin failures++; $display("FAIL known_locked_after1: got %b want 0", locked0); end
    send(4'h0, 1'b0);
    checks++; if (locked0 !== 1'b1) begin failures++; $display("FAIL known_locked_after2: got %b want 1", locked0); end
    checks++; if (locked1 !== 1'b1) begin failures++; $display("FAIL known_locked_drop: got %b want 1", locked1); end
    idle(2);
    checks++;
    if (out_q[0].size() != 2) begin failures++; $display("FAIL known_count_keep: got %0d want 2", out_q[0].size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < out_q[0].size()) ? out_q[0][i] : -1;
      checks++;
      if (got != exp0[i]) begin failures++; $display("FAIL known_data_keep[%0d]: got %0h want %0h", i, got, exp0[i]); end
    end
    got = (out_q[1].size() > 0) ? out_q[1][0] : -1;
    checks++; if (out_q[1].size() != 1) begin failures++; $display("FAIL known_count_drop: got %0d want 1", out_q[1].size()); end
    checks++; if (got != 7) begin failures++; $display("FAIL known_data_drop: got %0h want 7", got); end
    checks++; if (cnt0 !== 16'd2) begin failures++; $display("FAIL known_cnt_keep: got %0d want 2", cnt0); end
    checks++; if (cnt1 !== 16'd1) begin failures++; $display("FAIL known_cnt_drop: got %0d want 1", cnt1); end
  endtask

  task automatic test_random_stream();
    int     plain[64];
    int     scr[64];
    bit     line[$];
    int     seed_state;
    int_q_t exp;
    bit     a;
    do_reset();
    seed_state = int'($urandom_range(1, 127));
    for (int b = 0; b < 7; b++) line.push_back(bit'((seed_state >> b) & 1));
    for (int i = 0; i < 64; i++) begin
      plain[i] = int'($urandom_range(0, 15));
      scr[i] = 0;
      for (int b = 0; b < 4; b++) begin
        int k = line.size();
        bit s = bit'((plain[i] >> b) & 1) ^ line[k-4] ^ line[k-7];
        line.push_back(s);
        scr[i] = scr[i] | (int'(s) << b);
      end
    end
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 4'h0, 1'($urandom_range(0, 1)), 1'b0, a);
      send(4'(scr[i]), 1'b1);
    end
    idle(4);
    checks++;
    if (out_q[0].size() != 64) begin failures++; $display("FAIL rand_count: got %0d want 64", out_q[0].size()); end
    for (int i = 2; i < 64 && i < out_q[0].size(); i++) begin
      checks++;
      if (out_q[0][i] != plain[i]) begin
        failures++;
        $display("FAIL rand_plain[%0d]: got %0h want %0h", i, out_q[0][i], plain[i]);
      end
    end
    for (int u = 0; u < 3; u++) begin
      exp = model(acc_q[u], u == 1);
      checks++;
      if (out_q[u].size() != exp.size()) begin
        failures++;
        $display("FAIL rand_model_count[dut%0d]: got %0d want %0d", u, out_q[u].size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < out_q[u].size(); i++) begin
        checks++;
        if (out_q[u][i] != exp[i]) begin
          failures++;
          $display("FAIL rand_model[dut%0d][%0d]: got %0h want %0h", u, i, out_q[u][i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    int_q_t exp;
    int     want;
    bit     a;
    do_reset();
    send(4'h5, 1'b0);
    send(4'hA, 1'b0);
    exp = model(acc_q[0], 1'b0);
    want = (exp.size() > 0) ? exp[exp.size()-1] : -1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'h3, 1'b0, 1'b0, a);
      checks++; if (a) begin failures++; $display("FAIL stall_s_ready[%0d]: got 1 want 0", c); end
      checks++;
      if (if0.m_valid !== 1'b1 || int'(if0.m_data) != want) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h want valid=1 data=%0h", c, if0.m_valid, if0.m_data, want);
      end
    end
    send(4'h3, 1'b0);
    send(4'hC, 1'b0);
    idle(3);
    for (int u = 0; u < 3; u++) begin
      exp = model(acc_q[u], u == 1);
      checks++;
      if (out_q[u].size() != exp.size()) begin
        failures++;
        $display("FAIL stall_count[dut%0d]: got %0d want %0d", u, out_q[u].size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < out_q[u].size(); i++) begin
        checks++;
        if (out_q[u][i] != exp[i]) begin
          failures++;
          $display("FAIL stall_data[dut%0d][%0d]: got %0h want %0h", u, i, out_q[u][i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int_q_t exp;
    int     want0, want1;
    bit     a;
    do_reset();
    for (int i = 0; i < 3; i++) send(4'($urandom_range(0, 15)), 1'b0);
    idle(2);
    checks++; if (locked0 !== 1'b1) begin failures++; $display("FAIL flush_pre_locked: got %b want 1", locked0); end
    want0 = model(acc_q[0], 1'b0).size();
    want1 = model(acc_q[1], 1'b1).size();
    drive(1'b1, 4'h9, 1'b1, 1'b1, a);
    flush = 1'b0;
    s_valid = 1'b0;
    checks++; if (a) begin failures++; $display("FAIL flush_s_ready: got 1 want 0"); end
    checks++; if (locked0 !== 1'b0) begin failures++; $display("FAIL flush_locked: got %b want 0", locked0); end
    checks++; if (if0.m_valid !== 1'b0) begin failures++; $display("FAIL flush_m_valid: got %b want 0", if0.m_valid); end
    checks++; if (int'(cnt0) != want0) begin failures++; $display("FAIL flush_cnt_keep: got %0d want %0d", cnt0, want0); end
    checks++; if (int'(cnt1) != want1) begin failures++; $display("FAIL flush_cnt_drop: got %0d want %0d", cnt1, want1); end
    send(4'($urandom_range(0, 15)), 1'b0);
    send(4'($urandom_range(0, 15)), 1'b0);
    idle(2);
    for (int u = 0; u < 2; u++) begin
      exp = model(acc_q[u], u == 1);
      checks++;
      if (out_q[u].size() != exp.size()) begin
        failures++;
        $display("FAIL flush_count[dut%0d]: got %0d want %0d", u, out_q[u].size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < out_q[u].size(); i++) begin
        checks++;
        if (out_q[u][i] != exp[i]) begin
          failures++;
          $display("FAIL flush_data[dut%0d][%0d]: got %0h want %0h", u, i, out_q[u][i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    int want2, want0;
    bit a;
    do_reset();
    for (int i = 0; i < 17; i++) send(4'($urandom_range(0, 15)), 1'b0);
    idle(2);
    want0 = model(acc_q[0], 1'b0).size();
    want2 = model(acc_q[2], 1'b0).size() % 16;
    checks++; if (int'(cnt2) != want2) begin failures++; $display("FAIL wrap_cnt4: got %0d want %0d", cnt2, want2); end
    checks++; if (int'(cnt0) != want0) begin failures++; $display("FAIL wrap_cnt16: got %0d want %0d", cnt0, want0); end
    drive(1'b1, 4'h6, 1'b0, 1'b0, a);
    drive(1'b1, 4'hE, 1'b0, 1'b0, a);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if0.m_valid !== 1'b0 || if2.m_valid !== 1'b0) begin failures++; $display("FAIL async_m_valid: got %b%b want 00", if0.m_valid, if2.m_valid); end
    checks++; if (if0.m_data !== 4'h0 || if2.m_data !== 4'h0) begin failures++; $display("FAIL async_m_data: got %h/%h want 0/0", if0.m_data, if2.m_data); end
    checks++; if (locked0 !== 1'b0 || locked2 !== 1'b0) begin failures++; $display("FAIL async_locked: got %b%b want 00", locked0, locked2); end
    checks++; if (cnt0 !== 16'd0 || cnt2 !== 4'd0) begin failures++; $display("FAIL async_nib_cnt: got %0d/%0d want 0/0", cnt0, cnt2); end
    s_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_stream();
    test_back_to_back_stall();
    test_flush();
    test_wrap_and_async_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
